ram16k_arbiter: RTL and testbench

Two-requester, round-robin access arbiter in front of one RAM16K (16K x 16-bit).
- Latches one requester's transaction, drives the RAM's `en`/`rw`/`address`/`in` for exactly one cycle, captures read data, and returns a one-cycle acknowledge.
- Sits between two bus masters (e.g. CPU data port and a DMA/loader) and the RAM16K instance, which it owns exclusively.

---
 rtl/ram16k_arbiter_if.sv | 32 +++
 rtl/ram16k_arbiter.sv | 100 ++++++++++
 tb/tb_ram16k_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram16k_arbiter_if.sv
// rtl/ram16k_arbiter_if.sv - requester and RAM16K signal bundle for the arbiter.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the RAM.
interface ram16k_arbiter_if;
  logic        req0;
  logic        rw0;
  logic [13:0] addr0;
  logic [15:0] wdata0;
  logic        ack0;
  logic [15:0] rdata0;
  logic        req1;
  logic        rw1;
  logic [13:0] addr1;
  logic [15:0] wdata1;
  logic        ack1;
  logic [15:0] rdata1;
  logic        mem_en;
  logic        mem_rw;
  logic [13:0] mem_address;
  logic [15:0] mem_in;
  logic [15:0] mem_out;
  logic        busy;

  modport slave (
    input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, mem_out,
    output ack0, rdata0, ack1, rdata1, mem_en, mem_rw, mem_address, mem_in, busy
  );

  modport master (
    output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, mem_out,
    input  ack0, rdata0, ack1, rdata1, mem_en, mem_rw, mem_address, mem_in, busy
  );
endinterface

// File: rtl/ram16k_arbiter.sv
// rtl/ram16k_arbiter.sv - two-requester round-robin arbiter owning one RAM16K.
// Each access runs IDLE -> SERVE -> ACK. All outputs come from registers, so no req reaches an ack combinationally.
module ram16k_arbiter #(
  parameter bit PRIORITY_INIT = 1'b0
) (
  input logic             clk,
  input logic             reset,
  ram16k_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE, ACK} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sel;
  logic        r_last;
  logic        r_rw;
  logic [13:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata0;
  logic [15:0] r_rdata1;
  logic        w_grant;
  logic        w_load;
  logic        w_mem_en;
  logic        w_ack0;
  logic        w_ack1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_grant  = 1'b0;
    w_load   = 1'b0;
    w_mem_en = 1'b0;
    w_ack0   = 1'b0;
    w_ack1   = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie, the requester that was not served last wins.
        if (bus.req0 && bus.req1) w_grant = ~r_last;
        else                      w_grant = bus.req1;
        if (bus.req0 || bus.req1) begin
          w_load = 1'b1;
          w_next = SERVE;
        end
      end
      SERVE: begin
        w_mem_en = 1'b1;
        w_next   = ACK;
      end
      ACK: begin
        w_ack0 = ~r_sel;
        w_ack1 = r_sel;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel    <= 1'b0;
      r_last   <= ~PRIORITY_INIT;
      r_rw     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_load) begin
        r_sel   <= w_grant;
        r_rw    <= w_grant ? bus.rw1    : bus.rw0;
        r_addr  <= w_grant ? bus.addr1  : bus.addr0;
        r_wdata <= w_grant ? bus.wdata1 : bus.wdata0;
      end
      if (w_mem_en) begin
        r_last <= r_sel;
        if (!r_rw) begin
          if (r_sel) r_rdata1 <= bus.mem_out;
          else       r_rdata0 <= bus.mem_out;
        end
      end
    end
  end

  // rw is gated by SERVE so the RAM never sees en & rw together outside the access cycle.
  assign bus.mem_en      = w_mem_en;
  assign bus.mem_rw      = r_rw & w_mem_en;
  assign bus.mem_address = r_addr;
  assign bus.mem_in      = r_wdata;
  assign bus.ack0        = w_ack0;
  assign bus.ack1        = w_ack1;
  assign bus.rdata0      = r_rdata0;
  assign bus.rdata1      = r_rdata1;
  assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_ram16k_arbiter.sv
// tb/tb_ram16k_arbiter.sv - scoreboard bench for ram16k_arbiter with a behavioural RAM16K.
module tb_ram16k_arbiter;

  typedef struct {
    int          cyc_ack;
    bit          rw;
    logic [13:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  logic        clk;
  logic        reset;
  int          cyc;
  int          errors;
  int          checks;
  bit          prev_ack;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] ram [0:16383];

  ram16k_arbiter_if bus();

  ram16k_arbiter #(.PRIORITY_INIT(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.mem_en && bus.mem_rw) ram[bus.mem_address] <= bus.mem_in;
  assign bus.mem_out = ram[bus.mem_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mem_cmp(input exp_t e);
    chk("mem_rw", {31'd0, bus.mem_rw}, {31'd0, e.rw});
    chk("mem_address", {18'd0, bus.mem_address}, {18'd0, e.addr});
    if (e.rw) chk("mem_in", {16'd0, bus.mem_in}, {16'd0, e.wdata});
  endtask

  always @(negedge clk) begin
    chk("ack_exclusive", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
    if (!bus.mem_en) chk("mem_rw_idle", {31'd0, bus.mem_rw}, 32'd0);
    if (prev_ack) chk("ack_spacing", {31'd0, bus.ack0 | bus.ack1}, 32'd0);
    prev_ack = bus.ack0 | bus.ack1;
    if (bus.mem_en | bus.ack0 | bus.ack1) chk("busy_active", {31'd0, bus.busy}, 32'd1);
    if (bus.mem_en) begin
      if (q0.size() > 0 && q0[0].cyc_ack == cyc + 1)      mem_cmp(q0[0]);
      else if (q1.size() > 0 && q1[0].cyc_ack == cyc + 1) mem_cmp(q1[0]);
      else begin
        checks++;
        errors++;
        $display("FAIL mem_en_unexpected: mem_en=1 expected 0 (cycle %0d)", cyc);
      end
    end
    if (bus.ack0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack0_unexpected: ack0=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("ack0_cycle", cyc, e.cyc_ack);
        chk("rdata0", {16'd0, bus.rdata0}, {16'd0, e.rdata});
      end
    end
    if (bus.ack1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack1_unexpected: ack1=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("ack1_cycle", cyc, e.cyc_ack);
        chk("rdata1", {16'd0, bus.rdata1}, {16'd0, e.rdata});
      end
    end
  end

  // lat: cycles from driving req to the expected ack; rd: rdata value expected while ack is high.
  task automatic do_txn(input bit p, input bit rw, input logic [13:0] a, input logic [15:0] wd,
                        input logic [15:0] rd, input int lat, input bit hold);
    exp_t e;
    bit   seen;
    @(posedge clk);
    #1;
    e.cyc_ack = cyc + lat;
    e.rw      = rw;
    e.addr    = a;
    e.wdata   = wd;
    e.rdata   = rd;
    if (p) begin
      q1.push_back(e);
      bus.rw1 = rw; bus.addr1 = a; bus.wdata1 = wd; bus.req1 = 1'b1;
    end else begin
      q0.push_back(e);
      bus.rw0 = rw; bus.addr0 = a; bus.wdata0 = wd; bus.req0 = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = p ? bus.ack1 : bus.ack0;
    end
    chk(p ? "ack1_seen" : "ack0_seen", {31'd0, seen}, 32'd1);
    if (!hold) begin
      if (p) bus.req1 = 1'b0;
      else   bus.req0 = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    cyc = 0; errors = 0; checks = 0; prev_ack = 1'b0;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.rw0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.rw1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack0", {31'd0, bus.ack0}, 32'd0);
    chk("rst_ack1", {31'd0, bus.ack1}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_address", {18'd0, bus.mem_address}, 32'd0);
    chk("rst_mem_in", {16'd0, bus.mem_in}, 32'd0);
    chk("rst_rdata0", {16'd0, bus.rdata0}, 32'd0);
    chk("rst_rdata1", {16'd0, bus.rdata1}, 32'd0);
    reset = 1'b0;

    // First tie after reset: requester 0 wins, requester 1 follows three cycles later.
    fork
      do_txn(1'b0, 1'b1, 14'h2A5F, 16'hBEEF, 16'h0000, 2, 1'b0);
      do_txn(1'b1, 1'b1, 14'h0FFF, 16'h1234, 16'h0000, 5, 1'b0);
    join
    do_txn(1'b0, 1'b0, 14'h2A5F, 16'h0000, 16'hBEEF, 2, 1'b0);
    do_txn(1'b0, 1'b1, 14'h3FFF, 16'hC0DE, 16'hBEEF, 2, 1'b0);
    // Requester 0 served last, so this tie goes to requester 1.
    fork
      do_txn(1'b0, 1'b0, 14'h3FFF, 16'h0000, 16'hC0DE, 5, 1'b0);
      do_txn(1'b1, 1'b1, 14'h1000, 16'h5678, 16'h0000, 2, 1'b0);
    join
    do_txn(1'b1, 1'b0, 14'h0FFF, 16'h0000, 16'h1234, 2, 1'b0);
    do_txn(1'b1, 1'b0, 14'h1000, 16'h0000, 16'h5678, 2, 1'b0);
    chk("rdata0_untouched", {16'd0, bus.rdata0}, 32'h0000C0DE);
    do_txn(1'b1, 1'b1, 14'h0001, 16'h0F0F, 16'h5678, 2, 1'b0);
    chk("rdata1_after_write", {16'd0, bus.rdata1}, 32'h00005678);

    // req0 held continuously; req1 raised once. Acks go 0,1,0,0 at +2,+5,+8,+11.
    fork
      begin
        do_txn(1'b0, 1'b0, 14'h2A5F, 16'h0000, 16'hBEEF, 2, 1'b1);
        do_txn(1'b0, 1'b0, 14'h0001, 16'h0000, 16'h0F0F, 5, 1'b1);
        do_txn(1'b0, 1'b0, 14'h3FFF, 16'h0000, 16'hC0DE, 2, 1'b0);
      end
      do_txn(1'b1, 1'b0, 14'h0FFF, 16'h0000, 16'h1234, 5, 1'b0);
    join

    // Reset in the middle of SERVE.
    begin
      exp_t e;
      bit   in_serve;
      @(posedge clk);
      #1;
      e.cyc_ack = cyc + 2; e.rw = 1'b1; e.addr = 14'h0002; e.wdata = 16'h5555; e.rdata = 16'h0000;
      q0.push_back(e);
      bus.rw0 = 1'b1; bus.addr0 = 14'h0002; bus.wdata0 = 16'h5555; bus.req0 = 1'b1;
      in_serve = 1'b0;
      for (int i = 0; i < 10 && !in_serve; i++) begin
        @(negedge clk);
        in_serve = bus.mem_en;
      end
      chk("reset_test_serve", {31'd0, in_serve}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_mem_en", {31'd0, bus.mem_en}, 32'd0);
      chk("midrst_mem_rw", {31'd0, bus.mem_rw}, 32'd0);
      chk("midrst_ack0", {31'd0, bus.ack0}, 32'd0);
      chk("midrst_ack1", {31'd0, bus.ack1}, 32'd0);
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_rdata0", {16'd0, bus.rdata0}, 32'd0);
      chk("midrst_rdata1", {16'd0, bus.rdata1}, 32'd0);
      bus.req0 = 1'b0;
      q0.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("postrst_mem_address", {18'd0, bus.mem_address}, 32'd0);
      chk("postrst_mem_in", {16'd0, bus.mem_in}, 32'd0);
      @(posedge clk);
      #1;
      chk("postrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("postrst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    end

    // Last-served is restored by reset, so requester 0 wins the tie again.
    fork
      do_txn(1'b0, 1'b0, 14'h2A5F, 16'h0000, 16'hBEEF, 2, 1'b0);
      do_txn(1'b1, 1'b0, 14'h0FFF, 16'h0000, 16'h1234, 5, 1'b0);
    join

    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
